// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the UART boot loader: frame FSM states,
// receiver bit-FSM states, the frame start marker and the bit-period helper.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection, centre
// sampling, and one-cycle byte-valid / frame-error pulses after the stop bit.
module uart_rx
  import rom_loader_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_vld,
  output logic       o_ferr
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB + 1);

  rx_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  logic       vld_q, vld_d;
  logic       ferr_q, ferr_d;

  logic fall, half_tick, bit_tick;

  assign fall      = rx_prev_q & ~rx_sync_q;
  assign half_tick = (cnt_q == CNT_W'(HALF - 1));
  assign bit_tick  = (cnt_q == CNT_W'(CPB - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (half_tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_tick) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Stop-bit sample decides between a good byte and a framing error.
  always_comb begin
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    if (state_q == RX_STOP && bit_tick) begin
      vld_d  = rx_sync_q;
      ferr_d = ~rx_sync_q;
    end
  end

  assign o_byte = shift_q;
  assign o_vld  = vld_q;
  assign o_ferr = ferr_q;

endmodule

// File: rtl/rom_loader.sv
// UART boot loader: parses MAGIC/LEN/data[/CSUM] frames, writes words into the
// instruction ROM and holds the CPU in reset until loaded. ROM_LOADER_CSUM_EN adds the XOR checksum byte.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [31:0]       o_wdata,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);
`ifdef ROM_LOADER_CSUM_EN
  localparam loader_state_t LAST_ST = CSUM;
`else
  localparam loader_state_t LAST_ST = DONE;
`endif

  logic [7:0] rx_byte;
  logic       rx_vld, rx_ferr;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (i_rx),
    .o_byte (rx_byte),
    .o_vld  (rx_vld),
    .o_ferr (rx_ferr)
  );

  loader_state_t     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [15:0] n_w;
  logic [15:0] idx_inc;
  logic [31:0] word_ins;
  logic        csum_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef ROM_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) csum_q <= '0;
    else      csum_q <= csum_d;
  end

  // Running XOR covers both length bytes and every data byte, restarting on MAGIC.
  always_comb begin
    csum_d = csum_q;
    if (rx_vld) begin
      if (state_q inside {IDLE, DONE, ERROR}) csum_d = '0;
      else if (state_q inside {LEN_LO, LEN_HI, DATA}) csum_d = csum_q ^ rx_byte;
    end
  end

  assign csum_ok = (rx_byte == csum_q);
`else
  assign csum_ok = 1'b1;
`endif

  assign n_w     = {rx_byte, len_q[7:0]};
  assign idx_inc = idx_q + 16'd1;

  always_comb begin
    word_ins = word_q;
    word_ins[8*lane_q +: 8] = rx_byte;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (rx_ferr && (state_q inside {LEN_LO, LEN_HI, DATA, CSUM})) begin
      state_d = ERROR;
    end else if (rx_vld) begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (rx_byte == LOADER_MAGIC) state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d[7:0] = rx_byte;
          state_d    = LEN_HI;
        end
        LEN_HI: begin
          len_d = n_w;
          if ({1'b0, n_w} > MAX_WORDS) begin
            state_d = ERROR;
          end else if (n_w == 16'd0) begin
            state_d = LAST_ST;
          end else begin
            idx_d   = '0;
            lane_d  = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          word_d = word_ins;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = idx_q[ADDR_W-1:0];
            wdata_d = word_ins;
            idx_d   = idx_inc;
            if (idx_inc == len_q) state_d = LAST_ST;
          end
        end
        CSUM: state_d = csum_ok ? DONE : ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // CPU stays held in reset everywhere except after a complete, verified image.
  always_comb begin
    o_cpu_rst = (state_q != DONE);
    o_done    = (state_q == DONE);
    o_err     = (state_q == ERROR);
  end

  assign o_we    = we_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a table of frames with expected status/writes,
// plus hand sequences for glitch rejection, length boundary, framing error and async reset.
`timescale 1ns/1ps
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int CLK_HZ    = 1_000_000;
  localparam int BAUD      = 100_000;
  localparam int ADDR_W    = 10;
  localparam int CPB       = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_rx = 1'b1;
  logic              o_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [31:0]       o_wdata;
  logic              o_cpu_rst;
  logic              o_done;
  logic              o_err;

  always #500 clk = ~clk;

  rom_loader #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (i_rx),
    .o_we      (o_we),
    .o_waddr   (o_waddr),
    .o_wdata   (o_wdata),
    .o_cpu_rst (o_cpu_rst),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  typedef struct packed {
    logic [23:0] pre;
    logic [1:0]  npre;
    logic [15:0] n;
    logic [63:0] words;
    logic [1:0]  nsend;
    logic        bad_csum;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_wr;
  } vec_t;

  int n_checks = 0;
  int n_errs   = 0;
  int wr_total = 0;
  int rx_bytes = 0;
  logic [ADDR_W-1:0] wr_addr [256];
  logic [31:0]       wr_data [256];

  always @(negedge clk) begin
    if (o_we && wr_total < 256) begin
      wr_addr[wr_total] = o_waddr;
      wr_data[wr_total] = o_wdata;
      wr_total++;
    end
    if (dut.u_rx.o_vld) rx_bytes++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    i_rx = stop;
    repeat (CPB) @(negedge clk);
    i_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [23:0] pre, input logic [1:0] npre,
                              input logic [15:0] n, input logic [63:0] words,
                              input logic [1:0] nsend, input logic bad_csum,
                              input logic exp_done, input logic exp_err,
                              input logic [1:0] exp_wr);
    vec_t v;
    v.pre = pre; v.npre = npre; v.n = n; v.words = words; v.nsend = nsend;
    v.bad_csum = bad_csum; v.exp_done = exp_done; v.exp_err = exp_err; v.exp_wr = exp_wr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int r);
    int base;
    logic [7:0] b;
    logic [7:0] cs;
    base = wr_total;
    for (int i = 0; i < int'(v.npre); i++) send_byte(v.pre[8*i +: 8], 1'b1);
    send_byte(LOADER_MAGIC, 1'b1);
    send_byte(v.n[7:0], 1'b1);
    send_byte(v.n[15:8], 1'b1);
    cs = v.n[7:0] ^ v.n[15:8];
    for (int w = 0; w < int'(v.nsend); w++) begin
      for (int k = 0; k < 4; k++) begin
        b  = v.words[32*w + 8*k +: 8];
        cs = cs ^ b;
        send_byte(b, 1'b1);
      end
    end
`ifdef ROM_LOADER_CSUM_EN
    if (v.n <= 16'(MAX_WORDS)) send_byte(v.bad_csum ? 8'h00 : cs, 1'b1);
`endif
    repeat (5) @(negedge clk);
    check($sformatf("row%0d done", r), 32'(o_done), 32'(v.exp_done));
    check($sformatf("row%0d err", r), 32'(o_err), 32'(v.exp_err));
    check($sformatf("row%0d cpu_rst", r), 32'(o_cpu_rst), 32'(!v.exp_done));
    check($sformatf("row%0d wr_count", r), 32'(wr_total - base), 32'(v.exp_wr));
    for (int i = 0; i < int'(v.exp_wr) && base + i < wr_total; i++) begin
      check($sformatf("row%0d wr%0d addr", r, i), 32'(wr_addr[base+i]), 32'(i));
      check($sformatf("row%0d wr%0d data", r, i), wr_data[base+i], v.words[32*i +: 32]);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int base;
    int rx0;

    // Pre-bytes go first while the loader is still idle after reset.
    vecs.push_back(mk(24'h13FF00, 2'd3, 16'd1, 64'h0000_0000_CAFE_F00D, 2'd1, 1'b0, 1'b1, 1'b0, 2'd1));
    vecs.push_back(mk(24'h0, 2'd0, 16'd2, 64'hDEAD_BEEF_1234_5678, 2'd2, 1'b0, 1'b1, 1'b0, 2'd2));
`ifdef ROM_LOADER_CSUM_EN
    vecs.push_back(mk(24'h0, 2'd0, 16'd2, 64'hDEAD_BEEF_1234_5678, 2'd2, 1'b1, 1'b0, 1'b1, 2'd2));
    vecs.push_back(mk(24'h0, 2'd0, 16'd2, 64'hDEAD_BEEF_1234_5678, 2'd2, 1'b0, 1'b1, 1'b0, 2'd2));
`endif
    vecs.push_back(mk(24'h0, 2'd0, 16'h0401, 64'h0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0));
    vecs.push_back(mk(24'h0, 2'd0, 16'd0, 64'h0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0));

    repeat (3) @(negedge clk);
    check("rst cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("rst we", 32'(o_we), 32'd0);
    check("rst done", 32'(o_done), 32'd0);
    check("rst err", 32'(o_err), 32'd0);
    check("rst waddr", 32'(o_waddr), 32'd0);
    check("rst wdata", o_wdata, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Short low glitch in idle must not produce a byte.
    rx0 = rx_bytes;
    i_rx = 1'b0;
    repeat (3) @(negedge clk);
    i_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch rx_bytes", 32'(rx_bytes - rx0), 32'd0);
    check("glitch err", 32'(o_err), 32'd0);
    check("glitch cpu_rst", 32'(o_cpu_rst), 32'd1);

    foreach (vecs[r]) run_vec(vecs[r], r);

    // N equal to MAX_WORDS is accepted; a bad stop bit mid-data then errors.
    base = wr_total;
    send_byte(LOADER_MAGIC, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    check("maxlen err", 32'(o_err), 32'd0);
    check("maxlen cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("maxlen done", 32'(o_done), 32'd0);
    rx0 = rx_bytes;
    send_byte(8'h11, 1'b0);
    check("ferr err", 32'(o_err), 32'd1);
    check("ferr cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("ferr no byte", 32'(rx_bytes - rx0), 32'd0);
    check("ferr no write", 32'(wr_total - base), 32'd0);

    // Async reset in the middle of a data word.
    send_byte(LOADER_MAGIC, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    check("mid err", 32'(o_err), 32'd0);
    check("mid waddr held", 32'(o_waddr), 32'd1);
    check("mid wdata held", o_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    #100 rst = 1'b0;
    #1;
    check("arst cpu_rst", 32'(o_cpu_rst), 32'd1);
    check("arst done", 32'(o_done), 32'd0);
    check("arst err", 32'(o_err), 32'd0);
    check("arst we", 32'(o_we), 32'd0);
    check("arst waddr", 32'(o_waddr), 32'd0);
    check("arst wdata", o_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
